bin_bcd_seq: RTL and testbench
==============================

Name: bin_bcd_seq

Overview:
- Sequential double-dabble binary-to-BCD converter; one shift-and-add-3 step per clock.
- Parametrised successor to the combinational converter, for wide operands where the combinational adder depth breaks timing.
- Adds a valid/ready handshake on both sides, optional signed (two's-complement) input, and a significant-digit count for leading-zero blanking on display drivers.

Parameters:
- WIDTH, 32, binary input width; legal range 4..64 (elaboration-time assertion).
- SIGNED, 0, 1 = treat in_bin as two's complement and output sign plus magnitude; 0 = unsigned.
- DIGITS (localparam), (WIDTH*3)/10+1, number of BCD digits; exact for WIDTH <= 64.
- CW (localparam), $clog2(DIGITS+1), width of the digit-count output.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  converter can accept a word.
- in_bin  in  WIDTH  binary operand.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_bcd  out  4*DIGITS  BCD result, digit 0 (ones) in bits [3:0].
- out_neg  out  1  result is negative; always 0 when SIGNED=0.
- out_ndig  out  CW  count of significant digits, 1..DIGITS; value 0 reports 1.

Behaviour:
- Clocking and reset: one clock, synchronous active-high reset, as already decided.
- Reset values: FSM to IDLE; in_ready=1; out_valid=0; out_bcd=0; out_neg=0; out_ndig=1; internal shift and count registers cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture the magnitude into the binary shift register and clear the BCD accumulator.
  - Magnitude: if SIGNED and in_bin[WIDTH-1]=1, capture -in_bin (unsigned) and set neg_q=1; otherwise capture in_bin and set neg_q=0.
  - The most-negative value -2^(WIDTH-1) yields magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits.
  - Load bit counter = WIDTH; go to SHIFT.
- SHIFT, each cycle:
  - For every digit >= 5, add 3 (all digits in parallel, 4-bit wrap impossible).
  - Then shift {bcd,bin} left one bit.
  - Decrement the counter; when it reaches 0 after this step, go to DONE.
  - Exactly WIDTH SHIFT cycles.
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1.
  - out_bcd, out_neg and out_ndig are registered and stable until the handshake.
  - out_ndig = 1 + index of the most significant non-zero digit, or 1 if all digits are zero.
  - out_neg is forced to 0 when the magnitude is 0, so -0 never appears.
  - On out_ready, deassert out_valid and go to IDLE.
  - in_ready=0 in DONE; no overlap.
- Latency: acceptance edge at cycle 0 gives out_valid high from cycle WIDTH+1. Minimum initiation interval is WIDTH+2 cycles.
- out_ready held high before out_valid: completion occurs on the first DONE cycle.
- out_ready low: result held indefinitely; no data change while out_valid=1.
- Outputs between results: out_bcd/out_neg/out_ndig update only on entry to DONE and retain the last result otherwise.
- Reset mid-operation: rst in any state aborts immediately to reset values; a partial result is never presented.
- Simultaneous rst and in_valid: reset wins; the word is not accepted.
- Width rules: the BCD accumulator is 4*DIGITS bits. The bit counter is $clog2(WIDTH+1) bits. All add-3 operations are 4-bit.

Decomposition:
- Package bin_bcd_pkg:
  - FSM state enum (IDLE, SHIFT, DONE).
  - Function bcd_digits(width) returning (width*3)/10+1, shared with the combinational converter's users.
  - Function clog2-based count width.
- Sub-module bcd_dabble_digit: one 4-bit digit cell, combinational "if >=5 add 3". Instantiated DIGITS times in a generate loop, so the same cell can later serve a pipelined variant.
- Leading-digit count: a priority encoder inside the top module.

Test Plan:
- WIDTH=32, SIGNED=0, in_bin=4294967295, out_ready=1 -> out_bcd=0x4294967295, out_ndig=10, out_neg=0, out_valid exactly 33 cycles after the accept edge.
- WIDTH=16, SIGNED=1, in_bin=16'h8000 -> out_bcd=0x32768, out_neg=1, out_ndig=5. Then in_bin=16'hFFFF -> 0x00001, out_neg=1, out_ndig=1.
- WIDTH=8, SIGNED=0, in_bin=0 -> out_bcd=0x000, out_ndig=1, out_neg=0.
- Backpressure: hold out_ready=0 for 20 cycles in DONE with in_valid=1 -> in_ready=0 and out_bcd stable throughout. Raise out_ready -> one-cycle handshake, IDLE, next word accepted.
- Reset mid-SHIFT: assert rst on cycle 5 of a WIDTH=32 conversion -> next cycle out_valid=0, in_ready=1, out_bcd=0. A following conversion of 1234 gives 0x0000001234 with out_ndig=4.
- Randomised back-to-back unsigned/signed words with random out_ready -> scoreboard matches a reference model and the initiation interval is >= WIDTH+2.

Source files
------------

// File: rtl/bin_bcd_pkg.sv
// Shared types and sizing helpers for the binary-to-BCD converters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bin_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Decimal digits needed to hold any WIDTH-bit unsigned value
  // (exact for width <= 64).
  function automatic int bcd_digits(input int width);
    return (width * 3) / 10 + 1;
  endfunction

  // Bits needed to hold a count in 0..n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One double-dabble digit cell: adds 3 to a BCD digit of 5 or more.
// Latency: combinational.
// Backpressure: none.
// Ports: din - current digit, dout - adjusted digit ready for the shift.
module bcd_dabble_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Digits never exceed 9 between steps, so din + 3 stays within 4 bits.
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift-and-add-3 step per clock.
// Latency: result valid WIDTH cycles after the accept edge; initiation interval WIDTH+2.
// Backpressure: result held in DONE until out_ready; no new word accepted until then.
// Ports: clk/rst (sync, active high); in_valid/in_ready/in_bin input handshake;
//        out_valid/out_ready output handshake; out_bcd (digit 0 in [3:0]),
//        out_neg (sign, signed mode only), out_ndig (significant digits, >= 1).
module bin_bcd_seq
  import bin_bcd_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  bit SIGNED = 1'b0,
  localparam int DIGITS = bcd_digits(WIDTH),
  localparam int CW     = count_width(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic [CW-1:0]         out_ndig
);

  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int SW   = 4 * DIGITS + WIDTH;

  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("bin_bcd_seq: WIDTH must be in 4..64");
  end

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    bin_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [CNTW-1:0]     cnt_q;
  logic                neg_q;

  logic                load, step, finish;
  logic                neg_in;
  logic [WIDTH-1:0]    mag;
  logic [4*DIGITS-1:0] adj;
  logic [SW-1:0]       shifted;
  logic [4*DIGITS-1:0] bcd_shift;
  logic [WIDTH-1:0]    bin_shift;
  logic [CW-1:0]       ndig_nxt;

  // Two's-complement negate of the most negative value gives 2^(WIDTH-1),
  // which is still representable as a WIDTH-bit unsigned magnitude.
  assign neg_in = SIGNED && in_bin[WIDTH-1];
  assign mag    = neg_in ? ('0 - in_bin) : in_bin;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_dabble_digit u_digit (
      .din  (bcd_q[4*i +: 4]),
      .dout (adj[4*i +: 4])
    );
  end

  // Add-3 adjustment first, then one left shift of the combined {bcd, bin} register.
  assign shifted   = {adj, bin_q} << 1;
  assign bcd_shift = shifted[SW-1:WIDTH];
  assign bin_shift = shifted[WIDTH-1:0];

  // Leading-digit count on the value about to be latched; the highest
  // non-zero digit wins, an all-zero result reports one digit.
  always_comb begin
    ndig_nxt = CW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_shift[4*i +: 4] != 4'd0) begin
        ndig_nxt = CW'(i + 1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt_q == CNTW'(1)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      out_bcd  <= '0;
      out_neg  <= 1'b0;
      out_ndig <= CW'(1);
    end else begin
      state_q <= state_d;
      if (load) begin
        bin_q <= mag;
        bcd_q <= '0;
        cnt_q <= CNTW'(WIDTH);
        neg_q <= neg_in;
      end else if (step) begin
        bin_q <= bin_shift;
        bcd_q <= bcd_shift;
        cnt_q <= cnt_q - CNTW'(1);
      end
      // Result registers change only on the final step, so they hold the
      // last result through DONE and the following idle period.
      if (finish) begin
        out_bcd  <= bcd_shift;
        out_neg  <= neg_q && (bcd_shift != '0);
        out_ndig <= ndig_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bin_bcd_seq.sv
module tb_bin_bcd_seq;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   passed;
  int   fails;

  // Two converters: 32-bit unsigned (a_*) and 16-bit signed (b_*),
  // driven through one set of generic handshake signals selected by sel.
  logic        sel;
  logic        g_in_valid;
  logic        g_out_ready;
  logic [31:0] g_in_bin;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_neg;
  logic [39:0] a_out_bcd;
  logic [3:0]  a_out_ndig;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_neg;
  logic [19:0] b_out_bcd;
  logic [2:0]  b_out_ndig;

  logic        g_in_ready, g_out_valid, g_out_neg;
  logic [39:0] g_out_bcd;
  logic [3:0]  g_out_ndig;

  assign a_in_valid  = g_in_valid & ~sel;
  assign b_in_valid  = g_in_valid & sel;
  assign a_out_ready = sel ? 1'b1 : g_out_ready;
  assign b_out_ready = sel ? g_out_ready : 1'b1;
  assign g_in_ready  = sel ? b_in_ready : a_in_ready;
  assign g_out_valid = sel ? b_out_valid : a_out_valid;
  assign g_out_neg   = sel ? b_out_neg : a_out_neg;
  assign g_out_bcd   = sel ? {20'b0, b_out_bcd} : a_out_bcd;
  assign g_out_ndig  = sel ? {1'b0, b_out_ndig} : a_out_ndig;

  bin_bcd_seq #(.WIDTH(32), .SIGNED(1'b0)) u_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_bin    (g_in_bin),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_bcd   (a_out_bcd),
    .out_neg   (a_out_neg),
    .out_ndig  (a_out_ndig)
  );

  bin_bcd_seq #(.WIDTH(16), .SIGNED(1'b1)) u_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_bin    (g_in_bin[15:0]),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_bcd   (b_out_bcd),
    .out_neg   (b_out_neg),
    .out_ndig  (b_out_ndig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int prev_acc [2];
  bit have_prev [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by repeated division of the magnitude.
  function automatic void model(input bit s, input logic [31:0] v,
                                output logic [39:0] bcd, output logic neg, output int nd);
    longint m;
    longint t;
    if (s) m = longint'($signed(v[15:0]));
    else   m = longint'({32'b0, v});
    neg = (m < 0);
    if (neg) m = -m;
    t  = m;
    nd = 1;
    while (t >= 10) begin
      t = t / 10;
      nd++;
    end
    bcd = '0;
    for (int i = 0; i < 10; i++) begin
      bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
  endfunction

  // One conversion: hold = DONE cycles with out_ready low (0 = ready held
  // high beforehand); junk = keep in_valid high with garbage while busy.
  task automatic conv(input bit s, input logic [31:0] v, input int hold, input bit junk);
    logic [39:0] exp_bcd;
    logic        exp_neg;
    int          exp_nd;
    int          w;
    int          n;
    int          t_acc;
    logic [39:0] first_bcd;
    bit          stable;
    sel = s;
    w   = s ? 16 : 32;
    model(s, v, exp_bcd, exp_neg, exp_nd);
    n = 0;
    while (g_in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", g_in_ready, 1);
    g_in_bin    = v;
    g_in_valid  = 1'b1;
    g_out_ready = (hold == 0);
    @(negedge clk);
    t_acc = cyc;
    if (have_prev[s]) check("initiation_interval_ge_min", (t_acc - prev_acc[s]) >= w + 2, 1);
    prev_acc[s]  = t_acc;
    have_prev[s] = 1'b1;
    g_in_valid = junk;
    g_in_bin   = $urandom;
    // The accept cycle is cycle 0; after n further edges we are in cycle n+1.
    n = 0;
    while (g_out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_cycle", n + 1, w + 1);
    check("out_bcd", g_out_bcd, exp_bcd);
    check("out_neg", g_out_neg, exp_neg);
    check("out_ndig", g_out_ndig, exp_nd);
    first_bcd = g_out_bcd;
    stable    = 1'b1;
    for (int k = 0; k < hold; k++) begin
      if (g_in_ready !== 1'b0 || g_out_valid !== 1'b1 || g_out_bcd !== first_bcd) stable = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) begin
      check("held_result_stable", stable, 1);
      g_out_ready = 1'b1;
      @(negedge clk);
    end else begin
      @(negedge clk);
    end
    check("out_valid_after_handshake", g_out_valid, 0);
    check("in_ready_after_handshake", g_in_ready, 1);
    g_in_valid = 1'b0;
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    fails       = 0;
    sel         = 1'b0;
    g_in_valid  = 1'b0;
    g_out_ready = 1'b0;
    g_in_bin    = '0;
    have_prev[0] = 1'b0;
    have_prev[1] = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("reset_in_ready", g_in_ready, 1);
      check("reset_out_valid", g_out_valid, 0);
      check("reset_out_bcd", g_out_bcd, 0);
      check("reset_out_neg", g_out_neg, 0);
      check("reset_out_ndig", g_out_ndig, 1);
    end

    conv(1'b0, 32'hFFFF_FFFF, 0, 1'b0);
    conv(1'b0, 32'd0, 0, 1'b0);
    conv(1'b1, 32'h0000_8000, 0, 1'b0);
    conv(1'b1, 32'h0000_FFFF, 0, 1'b0);
    conv(1'b1, 32'd0, 0, 1'b0);
    conv(1'b1, 32'h0000_7FFF, 2, 1'b0);

    // Backpressure with a pending word on the input the whole time.
    conv(1'b0, 32'd12345678, 20, 1'b1);

    // Abort mid-conversion; in_valid during reset must not be taken.
    sel = 1'b0;
    @(negedge clk);
    g_in_bin    = 32'hFFFF_FFFF;
    g_in_valid  = 1'b1;
    g_out_ready = 1'b1;
    @(negedge clk);
    g_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst        = 1'b1;
    g_in_valid = 1'b1;
    g_in_bin   = 32'd999;
    @(negedge clk);
    rst        = 1'b0;
    g_in_valid = 1'b0;
    check("abort_out_valid", g_out_valid, 0);
    check("abort_in_ready", g_in_ready, 1);
    check("abort_out_bcd", g_out_bcd, 0);
    check("abort_out_ndig", g_out_ndig, 1);
    repeat (40) @(negedge clk);
    check("abort_no_late_result", g_out_valid, 0);
    conv(1'b0, 32'd1234, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      conv(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
